// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer: FIFO-buffered Philips I2S transmitter with programmable SCK divider
module i2s_tx_sequencer #(
  parameter int DW = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIVW = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIVW-1:0]               clk_div,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DW-1:0]                 s_left,
  input  logic [DW-1:0]                 s_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          underflow,
  output logic                          i2s_sck,
  output logic                          i2s_ws,
  output logic                          i2s_sd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * DW;
  localparam int KW = $clog2(FW);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [KW-1:0] k_q, k_d;
  logic [FW-1:0] sh_q, sh_d;
  logic sck_q, sck_d, ws_q, ws_d, uf_q, uf_d;
  logic push, pop, toggle, fall, last;
  assign s_ready = lvl_q != (AW+1)'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign toggle = state_q == RUN && div_q >= clk_div;
  assign fall = toggle && sck_q;
  assign last = k_q == KW'(FW - 1);
  assign fifo_level = lvl_q;
  assign busy = state_q == RUN;
  assign underflow = uf_q;
  assign i2s_sck = sck_q;
  assign i2s_ws = ws_q;
  assign i2s_sd = sh_q[FW-1];
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    k_d = k_q;
    sh_d = sh_q;
    sck_d = sck_q;
    ws_d = ws_q;
    uf_d = 1'b0;
    pop = 1'b0;
    if (state_q == IDLE) begin
      if (enable && lvl_q != '0) begin
        pop = 1'b1;
        state_d = RUN;
        sh_d = mem_q[rd_q];
        k_d = '0;
        div_d = '0;
        ws_d = 1'b0;
      end
    end else begin
      div_d = toggle ? '0 : div_q + 1'b1;
      sck_d = sck_q ^ toggle;
      if (fall && last) begin
        // frame boundary: next frame, zero fill, or stop with sck already low
        k_d = '0;
        ws_d = 1'b0;
        pop = enable && lvl_q != '0;
        uf_d = enable && lvl_q == '0;
        state_d = enable ? RUN : IDLE;
        sh_d = pop ? mem_q[rd_q] : '0;
      end else if (fall) begin
        k_d = k_q + 1'b1;
        sh_d = sh_q << 1;
        ws_d = k_d >= KW'(DW - 1) && k_d <= KW'(FW - 2);
      end
    end
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      div_q <= '0;
      k_q <= '0;
      sh_q <= '0;
      sck_q <= 1'b0;
      ws_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      div_q <= div_d;
      k_q <= k_d;
      sh_q <= sh_d;
      sck_q <= sck_d;
      ws_q <= ws_d;
      uf_q <= uf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {s_left, s_right};
  end
endmodule

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
- Transmit-side I2S sequencer for the Avalon I2S peripheral.
- Buffers stereo sample pairs in a small FIFO fed by the register block over a valid/ready stream.
- Generates SCK from a programmable divider and frames the samples onto SCK/WS/SD in Philips I2S format: MSB first, WS leads the MSB by one bit.
- Schedules frames back-to-back, fills with zero frames on underflow, and stops cleanly at frame boundaries.

Parameters:
- DW, 16, sample width per channel in bits (>=2).
- FIFO_DEPTH, 4, stereo-pair FIFO entries (power of 2, >=2).
- DIVW, 16, width of the clock-divider setting.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, run request; level-sensitive.
- clk_div, in, DIVW, SCK half-period minus 1, in clk cycles.
- s_valid, in, 1, sample pair valid.
- s_ready, out, 1, FIFO can accept a pair.
- s_left, in, DW, left sample.
- s_right, in, DW, right sample.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, entries held.
- busy, out, 1, sequencer in RUN.
- underflow, out, 1, one-clk pulse when a zero frame is substituted.
- i2s_sck, out, 1, serial bit clock.
- i2s_ws, out, 1, word select (0 = left, 1 = right).
- i2s_sd, out, 1, serial data.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset: FIFO empty, state IDLE, div_cnt=0, bit_cnt=0. Outputs: s_ready=1, fifo_level=0, busy=0, underflow=0, i2s_sck=0, i2s_ws=0, i2s_sd=0. Reset asserted mid-frame aborts the frame at the next clk edge with no completion.
- FIFO: push when s_valid&&s_ready. s_ready = !full and does not depend on a same-cycle pop. Pop is decided on registered contents only, so a pair pushed in cycle t is poppable at t+1 or later. Simultaneous push and pop leaves fifo_level unchanged.
- Divider (RUN only): div_cnt increments each clk. When div_cnt >= clk_div: div_cnt<=0 and i2s_sck toggles. The >= compare makes a lowered clk_div take effect without overrun. SCK period = 2*(clk_div+1) clk; clk_div=0 gives 2 clk.
- Frame: 64-bit... more precisely, a 2*DW-bit shift register {left,right}, bit index k = 0..2*DW-1, bit 0 = left MSB.
  - Presented values: i2s_sd = bit k.
  - i2s_ws = 1 for k in [DW-1, 2*DW-2], else 0. WS changes one bit before each channel's MSB.
- IDLE:
  - i2s_sck=0, i2s_ws=0, i2s_sd=0.
  - If enable && fifo_level>0: pop, load shift register, k=0, div_cnt=0, go to RUN. i2s_sd shows the left MSB on the next clk.
- RUN: each SCK falling edge (toggle 1->0) advances k and updates sd/ws in the same clk as the falling edge. SD and WS are stable across the SCK rising edge.
- Frame end: falling edge with k=2*DW-1. The same clk edge does one of:
  - enable=0: go to IDLE (sck already 0, ws=0, sd=0).
  - enable=1, FIFO non-empty: pop, load, k=0. Frames run back-to-back with no gap.
  - enable=1, FIFO empty: load zeros, k=0, underflow=1 for exactly one clk.
- enable dropped mid-frame: the current frame completes; the FIFO retains the remaining entries.
- busy = (state==RUN).
- A clk_div change mid-frame is allowed and applies at the next div_cnt compare.

Test Plan:
- Single frame: DW=16, clk_div=1. Push L=16'hA5C3, R=16'h0F01, then enable=1 and drop enable after 1 clk. Required: 32 SCK periods of 4 clk each. SD serialises A5C3 then 0F01 MSB-first. WS rises while L bit0 is on SD and falls while R bit0 is on SD. Then IDLE: busy=0, sck=0.
- Back-to-back: push 3 pairs with enable held. Required: 3 contiguous frames, no SCK gap, fifo_level steps 3->2->1->0. After the third frame, one zero frame with an underflow pulse of exactly 1 clk.
- FIFO full: push 5 pairs with enable=0 and FIFO_DEPTH=4. Required: s_ready=0 after the 4th push, 5th pair not accepted, fifo_level=4.
- Push and pop in the same cycle at frame boundary with fifo_level=2. Required: fifo_level stays 2, data order preserved.
- Reset mid-frame: assert reset at k=10 for 1 clk. Required: the next clk shows all outputs 0, fifo_level=0, busy=0.
- clk_div=0: SCK period is 2 clk and frame length is 64 clk. Changing clk_div from 3 to 1 mid-frame causes no SCK half-period longer than 4 clk.
